// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank game sequencer: FSM states,
// winner encoding and the keyboard codes the players use.
package tank_game_pkg;

    typedef enum logic [1:0] {
        ST_SELECT = 2'b00,
        ST_FIGHT  = 2'b01,
        ST_OVER   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam logic [7:0] KEY_A_NEXT  = 8'h1A;  // W
    localparam logic [7:0] KEY_A_READY = 8'h16;  // S
    localparam logic [7:0] KEY_B_NEXT  = 8'h0C;  // I
    localparam logic [7:0] KEY_B_READY = 8'h0E;  // K

    function automatic winner_t decide_winner(input logic [1:0] hp_a, input logic [1:0] hp_b);
        if (hp_a == 2'd0 && hp_b == 2'd0) return WIN_DRAW;
        else if (hp_a == 2'd0)            return WIN_B;
        else                              return WIN_A;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Turns the raw keycode level into a one-cycle press event: a non-zero code
// that differs from the code seen on the previous cycle.
module key_press_detect (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic       press,
    output logic [7:0] press_code
);

    logic [7:0] prev_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) prev_q <= 8'h00;
        else          prev_q <= keycode;
    end

    assign press      = (keycode != 8'h00) && (keycode != prev_q);
    assign press_code = keycode;

endmodule

// File: rtl/tank_game_ctrl.sv
// Game sequencer: tank selection, per-frame hit accounting with cooldown,
// hit points, winner decision and the timed return from OVER to SELECT.
module tank_game_ctrl #(
    parameter int HP_INIT      = 3,
    parameter int NUM_TANKS    = 4,
    parameter int COOLDOWN_FR  = 30,
    parameter int OVER_HOLD_FR = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       hit_A,
    input  logic       hit_B,
    output logic [1:0] currentState,
    output logic [1:0] currentTank_A,
    output logic [1:0] currentTank_B,
    output logic [1:0] hp_A,
    output logic [1:0] hp_B,
    output logic [1:0] winner,
    output logic       round_start
);
    import tank_game_pkg::*;

    localparam int CD_W   = $clog2(COOLDOWN_FR + 1);
    localparam int HOLD_W = $clog2(OVER_HOLD_FR + 1);

    logic       press;
    logic [7:0] press_code;

    key_press_detect u_keys (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .press      (press),
        .press_code (press_code)
    );

    state_t            state_q, state_d;
    winner_t           winner_q, winner_d;
    logic [1:0]        tank_a_q, tank_a_d, tank_b_q, tank_b_d;
    logic [1:0]        hp_a_q, hp_a_d, hp_b_q, hp_b_d;
    logic              round_start_q, round_start_d;
    logic              ready_a_q, ready_a_d, ready_b_q, ready_b_d;
    logic              lat_a_q, lat_a_d, lat_b_q, lat_b_d;
    logic [CD_W-1:0]   cd_a_q, cd_a_d, cd_b_q, cd_b_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    function automatic logic [1:0] next_tank(input logic [1:0] t);
        return (t == 2'(NUM_TANKS - 1)) ? 2'd0 : t + 2'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        tank_a_d      = tank_a_q;
        tank_b_d      = tank_b_q;
        hp_a_d        = hp_a_q;
        hp_b_d        = hp_b_q;
        round_start_d = 1'b0;
        ready_a_d     = ready_a_q;
        ready_b_d     = ready_b_q;
        lat_a_d       = lat_a_q;
        lat_b_d       = lat_b_q;
        cd_a_d        = cd_a_q;
        cd_b_d        = cd_b_q;
        hold_d        = hold_q;

        case (state_q)
            ST_SELECT: begin
                if (ready_a_q && ready_b_q) begin
                    state_d       = ST_FIGHT;
                    round_start_d = 1'b1;
                    hp_a_d        = 2'(HP_INIT);
                    hp_b_d        = 2'(HP_INIT);
                    winner_d      = WIN_NONE;
                    cd_a_d        = '0;
                    cd_b_d        = '0;
                    lat_a_d       = 1'b0;
                    lat_b_d       = 1'b0;
                    ready_a_d     = 1'b0;
                    ready_b_d     = 1'b0;
                end else if (press) begin
                    case (press_code)
                        KEY_A_NEXT:  if (!ready_a_q) tank_a_d = next_tank(tank_a_q);
                        KEY_B_NEXT:  if (!ready_b_q) tank_b_d = next_tank(tank_b_q);
                        KEY_A_READY: ready_a_d = 1'b1;
                        KEY_B_READY: ready_b_d = 1'b1;
                        default:     ;
                    endcase
                end
            end

            ST_FIGHT: begin
                if (hp_a_q == 2'd0 || hp_b_q == 2'd0) begin
                    state_d  = ST_OVER;
                    hold_d   = '0;
                    winner_d = decide_winner(hp_a_q, hp_b_q);
                    lat_a_d  = 1'b0;
                    lat_b_d  = 1'b0;
                end else begin
                    lat_a_d = frame_tick ? 1'b0 : (lat_a_q | hit_A);
                    lat_b_d = frame_tick ? 1'b0 : (lat_b_q | hit_B);
                    // Positions are being reset during the round_start cycle, so its tick deals no damage.
                    if (frame_tick && !round_start_q) begin
                        if ((lat_a_q | hit_A) && cd_a_q == '0 && hp_a_q != 2'd0) begin
                            hp_a_d = hp_a_q - 2'd1;
                            cd_a_d = CD_W'(COOLDOWN_FR);
                        end else if (cd_a_q != '0) begin
                            cd_a_d = cd_a_q - 1'b1;
                        end
                        if ((lat_b_q | hit_B) && cd_b_q == '0 && hp_b_q != 2'd0) begin
                            hp_b_d = hp_b_q - 2'd1;
                            cd_b_d = CD_W'(COOLDOWN_FR);
                        end else if (cd_b_q != '0) begin
                            cd_b_d = cd_b_q - 1'b1;
                        end
                    end
                end
            end

            ST_OVER: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_W'(OVER_HOLD_FR - 1)) begin
                        state_d = ST_SELECT;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_SELECT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_SELECT;
            winner_q      <= WIN_NONE;
            tank_a_q      <= 2'd0;
            tank_b_q      <= 2'd0;
            hp_a_q        <= 2'(HP_INIT);
            hp_b_q        <= 2'(HP_INIT);
            round_start_q <= 1'b0;
            ready_a_q     <= 1'b0;
            ready_b_q     <= 1'b0;
            lat_a_q       <= 1'b0;
            lat_b_q       <= 1'b0;
            cd_a_q        <= '0;
            cd_b_q        <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            tank_a_q      <= tank_a_d;
            tank_b_q      <= tank_b_d;
            hp_a_q        <= hp_a_d;
            hp_b_q        <= hp_b_d;
            round_start_q <= round_start_d;
            ready_a_q     <= ready_a_d;
            ready_b_q     <= ready_b_d;
            lat_a_q       <= lat_a_d;
            lat_b_q       <= lat_b_d;
            cd_a_q        <= cd_a_d;
            cd_b_q        <= cd_b_d;
            hold_q        <= hold_d;
        end
    end

    assign currentState  = state_q;
    assign currentTank_A = tank_a_q;
    assign currentTank_B = tank_b_q;
    assign hp_A          = hp_a_q;
    assign hp_B          = hp_b_q;
    assign winner        = winner_q;
    assign round_start   = round_start_q;

endmodule

// File: tb/tb_tank_game_ctrl.sv
// Bench for tank_game_ctrl: selection vector table, directed round sequences
// and a randomized run against a behavioural model of the game rules.
module tb_tank_game_ctrl;
    import tank_game_pkg::*;

    localparam int HP_INIT      = 3;
    localparam int NUM_TANKS    = 4;
    localparam int COOLDOWN_FR  = 30;
    localparam int OVER_HOLD_FR = 120;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       hit_A = 1'b0;
    logic       hit_B = 1'b0;
    logic [1:0] currentState, currentTank_A, currentTank_B, hp_A, hp_B, winner;
    logic       round_start;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    tank_game_ctrl #(
        .HP_INIT      (HP_INIT),
        .NUM_TANKS    (NUM_TANKS),
        .COOLDOWN_FR  (COOLDOWN_FR),
        .OVER_HOLD_FR (OVER_HOLD_FR)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .keycode       (keycode),
        .hit_A         (hit_A),
        .hit_B         (hit_B),
        .currentState  (currentState),
        .currentTank_A (currentTank_A),
        .currentTank_B (currentTank_B),
        .hp_A          (hp_A),
        .hp_B          (hp_B),
        .winner        (winner),
        .round_start   (round_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame(input bit ha, input bit hb);
        hit_A = ha; hit_B = hb;
        cycle();
        hit_A = 1'b0; hit_B = 1'b0;
        cycle();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        cycle();
        keycode = 8'h00;
        cycle();
    endtask

    function automatic logic [12:0] outs();
        return {currentState, currentTank_A, currentTank_B, hp_A, hp_B, winner, round_start};
    endfunction

    // ---------------- behavioural model ----------------
    int m_state, m_ta, m_tb, m_hp_a, m_hp_b, m_win, m_cd_a, m_cd_b, m_hold;
    bit m_rs, m_rdy_a, m_rdy_b, m_lat_a, m_lat_b;
    logic [7:0] m_prev;

    task automatic model_reset();
        m_state = 0; m_ta = 0; m_tb = 0; m_hp_a = HP_INIT; m_hp_b = HP_INIT; m_win = 0;
        m_cd_a = 0; m_cd_b = 0; m_hold = 0; m_rs = 0; m_rdy_a = 0; m_rdy_b = 0;
        m_lat_a = 0; m_lat_b = 0; m_prev = 8'h00;
    endtask

    task automatic apply_frame(input bit hit, inout int hp, inout int cd);
        if (hit && cd == 0 && hp > 0) begin
            hp = hp - 1;
            cd = COOLDOWN_FR;
        end else if (cd > 0) begin
            cd = cd - 1;
        end
    endtask

    task automatic model_edge(input logic [7:0] key, input bit tk, input bit ha, input bit hb);
        bit ev, rs_next;
        ev = (key != 8'h00) && (key != m_prev);
        m_prev = key;
        rs_next = 1'b0;
        if (m_state == 0) begin
            if (m_rdy_a && m_rdy_b) begin
                m_state = 1; rs_next = 1'b1; m_hp_a = HP_INIT; m_hp_b = HP_INIT; m_win = 0;
                m_cd_a = 0; m_cd_b = 0; m_lat_a = 0; m_lat_b = 0; m_rdy_a = 0; m_rdy_b = 0;
            end else if (ev) begin
                if (key == KEY_A_NEXT && !m_rdy_a) m_ta = (m_ta + 1) % NUM_TANKS;
                if (key == KEY_B_NEXT && !m_rdy_b) m_tb = (m_tb + 1) % NUM_TANKS;
                if (key == KEY_A_READY) m_rdy_a = 1'b1;
                if (key == KEY_B_READY) m_rdy_b = 1'b1;
            end
        end else if (m_state == 1) begin
            if (m_hp_a == 0 || m_hp_b == 0) begin
                m_win   = (m_hp_a == 0 && m_hp_b == 0) ? 3 : (m_hp_a == 0) ? 2 : 1;
                m_state = 2;
                m_hold  = 0;
            end else begin
                if (tk && !m_rs) begin
                    apply_frame(m_lat_a | ha, m_hp_a, m_cd_a);
                    apply_frame(m_lat_b | hb, m_hp_b, m_cd_b);
                end
                if (tk) begin
                    m_lat_a = 1'b0; m_lat_b = 1'b0;
                end else begin
                    m_lat_a = m_lat_a | ha; m_lat_b = m_lat_b | hb;
                end
            end
        end else if (tk) begin
            m_hold++;
            if (m_hold == OVER_HOLD_FR) begin
                m_state = 0;
                m_hold  = 0;
            end
        end
        m_rs = rs_next;
    endtask

    function automatic logic [12:0] model_pack();
        return {2'(m_state), 2'(m_ta), 2'(m_tb), 2'(m_hp_a), 2'(m_hp_b), 2'(m_win), m_rs};
    endfunction

    // ---------------- selection table ----------------
    typedef struct {
        logic [7:0] key;
        logic [1:0] ta;
        logic [1:0] tb;
        logic [1:0] st;
        logic       rs;
    } vec_t;

    vec_t vecs[22];

    initial begin
        logic [7:0] k;
        bit         tk, ha, hb;
        int         frame_cnt;

        vecs[0]  = '{8'h1A, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{8'h1A, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[2]  = '{8'h1A, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[3]  = '{8'h00, 2'd1, 2'd0, 2'd0, 1'b0};
        vecs[4]  = '{8'h1A, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[5]  = '{8'h00, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[6]  = '{8'h16, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[7]  = '{8'h00, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[8]  = '{8'h1A, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[9]  = '{8'h0C, 2'd2, 2'd1, 2'd0, 1'b0};
        vecs[10] = '{8'h00, 2'd2, 2'd1, 2'd0, 1'b0};
        vecs[11] = '{8'h0C, 2'd2, 2'd2, 2'd0, 1'b0};
        vecs[12] = '{8'h00, 2'd2, 2'd2, 2'd0, 1'b0};
        vecs[13] = '{8'h0C, 2'd2, 2'd3, 2'd0, 1'b0};
        vecs[14] = '{8'h00, 2'd2, 2'd3, 2'd0, 1'b0};
        vecs[15] = '{8'h0C, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[16] = '{8'h00, 2'd2, 2'd0, 2'd0, 1'b0};
        vecs[17] = '{8'h0C, 2'd2, 2'd1, 2'd0, 1'b0};
        vecs[18] = '{8'h0E, 2'd2, 2'd1, 2'd0, 1'b0};
        vecs[19] = '{8'h0E, 2'd2, 2'd1, 2'd1, 1'b1};
        vecs[20] = '{8'h00, 2'd2, 2'd1, 2'd1, 1'b0};
        vecs[21] = '{8'h1A, 2'd2, 2'd1, 2'd1, 1'b0};

        // Reset values
        cycle();
        cycle();
        check("reset_state",  32'(currentState),  32'd0);
        check("reset_tanks",  32'({currentTank_A, currentTank_B}), 32'd0);
        check("reset_hp",     32'({hp_A, hp_B}), 32'({2'd3, 2'd3}));
        check("reset_winner", 32'(winner), 32'd0);
        check("reset_rs",     32'(round_start), 32'd0);
        Reset_n = 1'b1;
        cycle();

        // Selection, hold/no-repeat, ready lockout, wrap, round start
        for (int i = 0; i < 22; i++) begin
            keycode = vecs[i].key;
            cycle();
            check($sformatf("sel_vec%0d", i),
                  32'({currentState, currentTank_A, currentTank_B, round_start}),
                  32'({vecs[i].st, vecs[i].ta, vecs[i].tb, vecs[i].rs}));
        end
        keycode = 8'h00;
        check("round_hp", 32'({hp_A, hp_B, winner}), 32'({2'd3, 2'd3, 2'd0}));

        // Long hit within one frame costs one hp, only at the tick
        hit_A = 1'b1;
        for (int i = 0; i < 200; i++) cycle();
        check("hit_no_tick_hp_a", 32'(hp_A), 32'd3);
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0; hit_A = 1'b0;
        check("hit_tick_hp", 32'({hp_A, hp_B}), 32'({2'd2, 2'd3}));

        // Cooldown window
        for (int i = 0; i < COOLDOWN_FR; i++) frame(1'b1, 1'b0);
        check("cooldown_hp_a", 32'(hp_A), 32'd2);
        frame(1'b1, 1'b0);
        check("after_cooldown_hp_a", 32'(hp_A), 32'd1);

        // Draw: both to zero in the same frame
        frame(1'b0, 1'b1);
        check("hp_1_2", 32'({hp_A, hp_B}), 32'({2'd1, 2'd2}));
        for (int i = 0; i < COOLDOWN_FR; i++) frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        check("hp_1_1", 32'({hp_A, hp_B}), 32'({2'd1, 2'd1}));
        for (int i = 0; i < COOLDOWN_FR; i++) frame(1'b0, 1'b0);
        frame(1'b1, 1'b1);
        check("hp_0_0_still_fight", 32'({currentState, hp_A, hp_B}), 32'({2'd1, 2'd0, 2'd0}));
        cycle();
        check("over_draw", 32'({currentState, winner}), 32'({2'd2, 2'd3}));

        // OVER hold for exactly OVER_HOLD_FR ticks, hits ignored
        for (int i = 0; i < OVER_HOLD_FR - 1; i++) frame(1'b1, 1'b1);
        check("over_hold_119", 32'(currentState), 32'd2);
        frame(1'b0, 1'b0);
        check("over_to_select", 32'(outs()), 32'({2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3, 1'b0}));
        press(KEY_A_NEXT);
        check("ready_a_cleared", 32'(currentTank_A), 32'd3);
        press(KEY_B_NEXT);
        check("ready_b_cleared", 32'(currentTank_B), 32'd2);

        // Tick coincident with round_start deals no damage
        press(KEY_A_READY);
        keycode = KEY_B_READY;
        cycle();
        keycode = 8'h00;
        cycle();
        check("round2_start", 32'({currentState, round_start, hp_A, hp_B, winner}),
              32'({2'd1, 1'b1, 2'd3, 2'd3, 2'd0}));
        frame_tick = 1'b1; hit_A = 1'b1; hit_B = 1'b1;
        cycle();
        frame_tick = 1'b0; hit_A = 1'b0; hit_B = 1'b0;
        check("rs_tick_no_damage", 32'({round_start, hp_A, hp_B}), 32'({1'b0, 2'd3, 2'd3}));

        // Asynchronous reset mid-fight at hp 1/2
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b1);
        for (int i = 0; i < COOLDOWN_FR; i++) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        check("pre_reset_hp", 32'({currentState, hp_A, hp_B}), 32'({2'd1, 2'd1, 2'd2}));
        #3;
        Reset_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'({2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 1'b0}));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Randomized run against the model
        Reset_n = 1'b0;
        cycle();
        Reset_n = 1'b1;
        model_reset();
        k = 8'h00;
        frame_cnt = 3;
        for (int c = 0; c < 6000; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 5 && r < 8) begin
                k = 8'h00;
            end else if (r >= 8) begin
                case ($urandom_range(0, 4))
                    0:       k = KEY_A_NEXT;
                    1:       k = KEY_A_READY;
                    2:       k = KEY_B_NEXT;
                    3:       k = KEY_B_READY;
                    default: k = 8'h55;
                endcase
            end
            if (frame_cnt == 0) begin
                tk = 1'b1;
                frame_cnt = $urandom_range(1, 5);
            end else begin
                tk = 1'b0;
                frame_cnt--;
            end
            ha = ($urandom_range(0, 15) == 0);
            hb = ($urandom_range(0, 15) == 0);
            keycode = k; frame_tick = tk; hit_A = ha; hit_B = hb;
            model_edge(k, tk, ha, hb);
            cycle();
            check($sformatf("model_c%0d", c), 32'(outs()), 32'(model_pack()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
